// File: rtl/pulse_hold_if.sv
// Control/status bundle between pulse_hold_gen and the logic driving its
// switch, write and auto-repeat inputs.
interface pulse_hold_if #(
  parameter int unsigned N_SW = 4
) ();
  logic            write;
  logic            auto_en;
  logic [N_SW-1:0] sw;
  logic            out;
  logic            tick;
  logic            done;
  logic            busy;

  modport master (output write, auto_en, sw, input out, tick, done, busy);
  modport slave  (input write, auto_en, sw, output out, tick, done, busy);
endinterface

// File: rtl/pulse_hold_gen.sv
// Hold-pulse generator: a write edge (or auto mode) produces an output pulse
// lasting the weighted sum of the selected switches, measured in divider ticks.
module pulse_hold_gen #(
  parameter int unsigned            N_SW      = 4,
  parameter int unsigned            CNT_W     = 10,
  parameter int unsigned            DIV       = 5208,
  parameter logic [N_SW*CNT_W-1:0]  WEIGHTS   = {10'd54, 10'd87, 10'd120, 10'd131},
  parameter int unsigned            GAP_TICKS = 16
) (
  input  logic         sysclk,
  input  logic         rst,
  pulse_hold_if.slave  bus_if
);

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SUM_W = CNT_W + 3;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_GAP,
    ST_FIN
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               tick_q, tick_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic               out_q, out_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               req_q, req_d;
  logic               write_q;

  logic [SUM_W-1:0]   sum_c;
  logic [CNT_W-1:0]   total_c;
  logic               sw_any_c;
  logic               write_edge_c;
  logic               req_pend_c;

  // Tick divider: tick_q is high for the cycle in which the count sits at DIV-1
  always_comb begin
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    tick_d = (div_d == DIV_LAST);
  end

  // Weighted switch total, saturated to the counter range
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < N_SW; i++) begin
      if (bus_if.sw[i]) begin
        sum_c = sum_c + SUM_W'(WEIGHTS[i*CNT_W +: CNT_W]);
      end
    end
    total_c = (sum_c[SUM_W-1:CNT_W] != '0) ? '1 : sum_c[CNT_W-1:0];
  end

  assign sw_any_c     = |bus_if.sw;
  assign write_edge_c = bus_if.write & ~write_q;
  // An edge arriving on the same cycle as an IDLE tick still counts as a request
  assign req_pend_c   = req_q | write_edge_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    out_d   = out_q;
    done_d  = 1'b0;
    req_d   = req_q;

    if ((state_q == ST_IDLE) && write_edge_c) begin
      req_d = 1'b1;
    end

    if (tick_q) begin
      case (state_q)
        ST_IDLE: begin
          req_d = 1'b0;
          if ((req_pend_c || bus_if.auto_en) && sw_any_c) begin
            total_d = total_c;
            cnt_d   = '0;
            out_d   = 1'b1;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_q == total_q - 1'b1) begin
            cnt_d   = '0;
            out_d   = 1'b0;
            done_d  = 1'b1;
            state_d = bus_if.auto_en ? ST_GAP : ST_FIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            if (bus_if.auto_en && sw_any_c) begin
              total_d = total_c;
              out_d   = 1'b1;
              state_d = ST_HOLD;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_FIN: begin
          if (!bus_if.write) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      tick_q  <= 1'b0;
      cnt_q   <= '0;
      total_q <= '0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      req_q   <= req_d;
      write_q <= bus_if.write;
    end
  end

  assign bus_if.out  = out_q;
  assign bus_if.tick = tick_q;
  assign bus_if.done = done_q;
  assign bus_if.busy = busy_q;

endmodule

// File: tb/tb_pulse_hold_gen.sv
// Bench for pulse_hold_gen: two instances (CNT_W=10 and a saturating CNT_W=8)
// share stimulus and are checked every cycle against a tick-level model.
`timescale 1ns/1ps
module tb_pulse_hold_gen;

  localparam int DIV = 4;
  localparam int GAP = 2;
  localparam int WT[4] = '{131, 120, 87, 54};
  localparam int CW[2] = '{10, 8};

  logic       clk;
  logic       rst;
  logic       tb_write;
  logic       tb_auto;
  logic [3:0] tb_sw;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pulse_hold_if #(.N_SW(4)) if_a ();
  pulse_hold_if #(.N_SW(4)) if_b ();

  assign if_a.write   = tb_write;
  assign if_a.auto_en = tb_auto;
  assign if_a.sw      = tb_sw;
  assign if_b.write   = tb_write;
  assign if_b.auto_en = tb_auto;
  assign if_b.sw      = tb_sw;

  pulse_hold_gen #(
    .N_SW(4), .CNT_W(10), .DIV(DIV),
    .WEIGHTS({10'd54, 10'd87, 10'd120, 10'd131}), .GAP_TICKS(GAP)
  ) u_a (.sysclk(clk), .rst(rst), .bus_if(if_a));

  pulse_hold_gen #(
    .N_SW(4), .CNT_W(8), .DIV(DIV),
    .WEIGHTS({8'd54, 8'd87, 8'd120, 8'd131}), .GAP_TICKS(GAP)
  ) u_b (.sysclk(clk), .rst(rst), .bus_if(if_b));

  logic d_out[2], d_tick[2], d_done[2], d_busy[2];
  assign d_out[0]  = if_a.out;   assign d_out[1]  = if_b.out;
  assign d_tick[0] = if_a.tick;  assign d_tick[1] = if_b.tick;
  assign d_done[0] = if_a.done;  assign d_done[1] = if_b.done;
  assign d_busy[0] = if_a.busy;  assign d_busy[1] = if_b.busy;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, act, exp);
    end
  endtask

  function automatic int model_total(input logic [3:0] s, input int cw);
    int sum;
    sum = 0;
    for (int i = 0; i < 4; i++) if (s[i]) sum += WT[i];
    return (sum > (1 << cw) - 1) ? (1 << cw) - 1 : sum;
  endfunction

  // Reference model: ticks of high / gap remaining, a release wait and a pending request
  int m_hold[2] = '{0, 0};
  int m_gap[2]  = '{0, 0};
  bit m_fin[2]  = '{0, 0};
  bit m_pend[2] = '{0, 0};
  bit m_done[2] = '{0, 0};
  bit m_prevw   = 1'b0;
  int cyc       = 0;

  initial begin
    bit tick_now, edge_w, idle;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        cyc = 0;
        m_prevw = 1'b0;
        for (int k = 0; k < 2; k++) begin
          m_hold[k] = 0; m_gap[k] = 0; m_fin[k] = 0; m_pend[k] = 0; m_done[k] = 0;
        end
      end else begin
        tick_now = ((cyc % DIV) == DIV - 1);
        edge_w   = tb_write && !m_prevw;
        for (int k = 0; k < 2; k++) begin
          idle = (m_hold[k] == 0) && (m_gap[k] == 0) && !m_fin[k];
          m_done[k] = 1'b0;
          if (idle && edge_w) m_pend[k] = 1'b1;
          if (tick_now) begin
            if (m_hold[k] > 0) begin
              m_hold[k] = m_hold[k] - 1;
              if (m_hold[k] == 0) begin
                m_done[k] = 1'b1;
                if (tb_auto) m_gap[k] = GAP;
                else m_fin[k] = 1'b1;
              end
            end else if (m_gap[k] > 0) begin
              m_gap[k] = m_gap[k] - 1;
              if (m_gap[k] == 0 && tb_auto && tb_sw != 0) m_hold[k] = model_total(tb_sw, CW[k]);
            end else if (m_fin[k]) begin
              if (!tb_write) m_fin[k] = 1'b0;
            end else begin
              if ((m_pend[k] || tb_auto) && tb_sw != 0) m_hold[k] = model_total(tb_sw, CW[k]);
              m_pend[k] = 1'b0;
            end
          end
        end
        m_prevw = tb_write;
        cyc++;
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("cmp_out%0d", k),  int'(d_out[k]),  int'(m_hold[k] > 0));
        chk($sformatf("cmp_tick%0d", k), int'(d_tick[k]), int'((cyc % DIV) == DIV - 1));
        chk($sformatf("cmp_done%0d", k), int'(d_done[k]), int'(m_done[k]));
        chk($sformatf("cmp_busy%0d", k), int'(d_busy[k]),
            int'(m_hold[k] > 0 || m_gap[k] > 0 || m_fin[k]));
      end
    end
  end

  // Run-length monitor on the DUT outputs for the directed literal checks
  int  rise_cnt[2] = '{0, 0};
  int  fall_cnt[2] = '{0, 0};
  int  done_cnt[2] = '{0, 0};
  int  hi_run[2]   = '{0, 0};
  int  lo_run[2]   = '{0, 0};
  int  last_hi[2]  = '{0, 0};
  int  last_lo[2]  = '{0, 0};
  bit  prev_out[2] = '{0, 0};
  bit  busy_s[2]   = '{0, 0};

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (d_out[k] && !prev_out[k]) begin
          rise_cnt[k]++; last_lo[k] = lo_run[k]; hi_run[k] = 1;
        end else if (d_out[k]) begin
          hi_run[k]++;
        end else if (prev_out[k]) begin
          fall_cnt[k]++; last_hi[k] = hi_run[k]; lo_run[k] = 1;
        end else begin
          lo_run[k]++;
        end
        if (d_done[k]) done_cnt[k]++;
        prev_out[k] = d_out[k];
        busy_s[k]   = d_busy[k];
      end
    end
  end

  task automatic drive(input bit w, input bit a, input logic [3:0] s);
    @(negedge clk);
    #1;
    tb_write = w; tb_auto = a; tb_sw = s;
  endtask

  task automatic wait_rise(input string nm, input int k, input int budget);
    int start, i;
    bit ok;
    start = rise_cnt[k]; i = 0; ok = 1'b0;
    while (!ok && i < budget) begin
      @(posedge clk); i++;
      if (rise_cnt[k] != start) ok = 1'b1;
    end
    chk(nm, int'(ok), 1);
  endtask

  task automatic wait_fall(input string nm, input int k, input int budget);
    int start, i;
    bit ok;
    start = fall_cnt[k]; i = 0; ok = 1'b0;
    while (!ok && i < budget) begin
      @(posedge clk); i++;
      if (fall_cnt[k] != start) ok = 1'b1;
    end
    chk(nm, int'(ok), 1);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int i;
    bit ok;
    i = 0; ok = 1'b0;
    while (!ok && i < budget) begin
      @(posedge clk); i++;
      if (!busy_s[0] && !busy_s[1]) ok = 1'b1;
    end
    chk(nm, int'(ok), 1);
  endtask

  int r0, r1, dn;

  initial begin
    tb_write = 1'b0; tb_auto = 1'b0; tb_sw = 4'b0000; rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out", int'(d_out[0]), 0);
    chk("rst_busy", int'(d_busy[0]), 0);
    chk("rst_tick", int'(d_tick[0]), 0);
    #1 rst = 1'b0;

    // First tick lands in the fourth cycle after reset release
    repeat (2) @(negedge clk);
    chk("first_tick_early", int'(d_tick[0]), 0);
    @(negedge clk);
    chk("first_tick", int'(d_tick[0]), 1);

    // Single hold of 131 ticks, then FIN while write stays high
    dn = done_cnt[0];
    drive(1'b1, 1'b0, 4'b0001);
    wait_rise("r031_rise", 0, 4 * DIV + 4);
    wait_fall("r031_fall", 0, 131 * DIV + 10);
    chk("r031_len", last_hi[0], 524);
    repeat (5 * DIV) @(negedge clk);
    chk("r031_done", done_cnt[0] - dn, 1);
    chk("r031_fin_busy", int'(busy_s[0]), 1);
    drive(1'b0, 1'b0, 4'b0001);
    wait_idle("r031_idle", 2 * DIV + 4);

    // All switches: 392 ticks on the wide instance, saturated 255 on the narrow one
    r0 = rise_cnt[0]; r1 = rise_cnt[1];
    drive(1'b1, 1'b0, 4'b1111);
    drive(1'b0, 1'b0, 4'b1111);
    wait_rise("r032_rise", 1, 4 * DIV + 4);
    wait_idle("r032_idle", 392 * DIV + 40);
    chk("r032_sat_len", last_hi[1], 1020);
    chk("r032_full_len", last_hi[0], 1568);
    chk("r032_pulses_a", rise_cnt[0] - r0, 1);
    chk("r032_pulses_b", rise_cnt[1] - r1, 1);

    // Write with no switches: no pulse, and the request does not linger
    r0 = rise_cnt[0];
    drive(1'b1, 1'b0, 4'b0000);
    drive(1'b0, 1'b0, 4'b0000);
    repeat (2 * DIV) @(negedge clk);
    chk("r033_busy", int'(d_busy[0]), 0);
    drive(1'b0, 1'b0, 4'b0001);
    repeat (3 * DIV) @(negedge clk);
    chk("r033_no_pulse", rise_cnt[0] - r0, 0);

    // Auto repeat: 54 high / 2 low, switch change takes effect on the following pulse
    drive(1'b0, 1'b1, 4'b1000);
    wait_rise("r034_rise1", 0, 2 * DIV + 4);
    wait_fall("r034_fall1", 0, 54 * DIV + 8);
    chk("r034_len1", last_hi[0], 216);
    wait_rise("r034_rise2", 0, GAP * DIV + 8);
    chk("r034_gap", last_lo[0], 8);
    repeat (20) @(negedge clk);
    drive(1'b0, 1'b1, 4'b0100);
    wait_fall("r034_fall2", 0, 54 * DIV + 8);
    chk("r034_latched", last_hi[0], 216);
    wait_rise("r034_rise3", 0, GAP * DIV + 8);
    wait_fall("r034_fall3", 0, 87 * DIV + 8);
    chk("r034_len3", last_hi[0], 348);
    drive(1'b0, 1'b0, 4'b0100);
    wait_idle("r034_idle", 4 * DIV + 8);

    // Second write during a hold is discarded
    r0 = rise_cnt[0];
    drive(1'b1, 1'b0, 4'b0010);
    drive(1'b0, 1'b0, 4'b0010);
    wait_rise("r036_rise", 0, 4 * DIV + 4);
    repeat (50) @(negedge clk);
    drive(1'b1, 1'b0, 4'b0010);
    drive(1'b0, 1'b0, 4'b0010);
    wait_idle("r036_idle", 120 * DIV + 20);
    repeat (3 * DIV) @(negedge clk);
    chk("r036_one_pulse", rise_cnt[0] - r0, 1);
    chk("r036_len", last_hi[0], 480);

    // Reset mid-hold truncates immediately with no done; next write gives a full pulse
    drive(1'b1, 1'b0, 4'b0001);
    drive(1'b0, 1'b0, 4'b0001);
    wait_rise("r035_rise", 0, 4 * DIV + 4);
    repeat (10 * DIV) @(negedge clk);
    chk("r035_mid", int'(d_out[0]), 1);
    dn = done_cnt[0];
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("r035_trunc", int'(d_out[0]), 0);
    chk("r035_busy", int'(d_busy[0]), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    chk("r035_no_done", done_cnt[0] - dn, 0);
    drive(1'b1, 1'b0, 4'b0001);
    drive(1'b0, 1'b0, 4'b0001);
    wait_rise("r035_rise2", 0, 4 * DIV + 4);
    wait_fall("r035_fall2", 0, 131 * DIV + 10);
    chk("r035_len", last_hi[0], 524);
    wait_idle("r035_idle", 2 * DIV + 4);

    // Randomized phase, checked by the per-cycle compare
    for (int it = 0; it < 250; it++) begin
      logic [3:0] s;
      s = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), s);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
      end
      repeat ($urandom_range(1, 60)) @(negedge clk);
    end

    drive(1'b0, 1'b0, 4'b0000);
    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
